// File: rtl/svm_win_sched.sv
// Linear-SVM scoring sequencer: one shared MAC over N_TERM terms per window, plus bias. Record at N_TERM+4 cycles after accept.
// One-deep pending slot; win_ready drops while it is occupied, and back-to-back windows score every N_TERM+3 cycles.
module svm_win_sched #(
    parameter int SW_W   = 11,
    parameter int N_TERM = 3780,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     win_valid,
    input  logic [SW_W-1:0]          win_id,
    output logic                     win_ready,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        term_addr,
    input  logic signed [DATA_W-1:0] feat_data,
    input  logic signed [DATA_W-1:0] w_data,
    input  logic signed [ACC_W-1:0]  bias,
    output logic                     det_valid,
    output logic [SW_W-1:0]          det_id,
    output logic signed [ACC_W-1:0]  det_score,
    output logic                     det_hit
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN1, DRAIN2, OUT} state_t;

    localparam logic [ADDR_W-1:0] LAST_TERM = ADDR_W'(N_TERM - 1);

    state_t                     state, state_nxt;
    logic                       pend_v;
    logic [SW_W-1:0]            pend_id;
    logic [SW_W-1:0]            cur_id;
    logic                       load;
    logic                       last_term;
    logic                       rd_v;
    logic                       prod_v;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    score;
    logic                       score_pos;
    logic [SW_W-1:0]            id_q;
    logic signed [ACC_W-1:0]    score_q;
    logic                       hit_q;

    assign last_term = (term_addr == LAST_TERM);
    assign win_ready = !pend_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pend_v) state_nxt = RUN;
            RUN:     if (last_term) state_nxt = DRAIN1;
            DRAIN1:  state_nxt = DRAIN2;
            DRAIN2:  state_nxt = OUT;
            OUT:     state_nxt = pend_v ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // OUT reloads directly from the pending slot so back-to-back windows skip IDLE.
    always_comb begin
        rd_en     = 1'b0;
        det_valid = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE:    load = pend_v;
            RUN:     rd_en = 1'b1;
            OUT: begin
                det_valid = 1'b1;
                load      = pend_v;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v  <= 1'b0;
            pend_id <= '0;
        end else if (win_valid && win_ready) begin
            pend_v  <= 1'b1;
            pend_id <= win_id;
        end else if (load) begin
            pend_v  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_id    <= '0;
            term_addr <= '0;
        end else if (load) begin
            cur_id    <= pend_id;
            term_addr <= '0;
        end else if (rd_en) begin
            term_addr <= last_term ? '0 : term_addr + 1'b1;
        end
    end

    // Memory data lands one cycle after rd_en; the product is registered before accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_v   <= 1'b0;
            prod_v <= 1'b0;
            prod   <= '0;
            acc    <= '0;
        end else begin
            rd_v   <= rd_en;
            prod_v <= rd_v;
            if (rd_v)
                prod <= feat_data * w_data;
            if (load)
                acc <= '0;
            else if (prod_v)
                acc <= acc + ACC_W'(prod);
        end
    end

    assign score     = acc + bias;
    assign score_pos = !score[ACC_W-1] && (score != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q    <= '0;
            score_q <= '0;
            hit_q   <= 1'b0;
        end else if (det_valid) begin
            id_q    <= cur_id;
            score_q <= score;
            hit_q   <= score_pos;
        end
    end

    // Record fields are live during OUT and hold their last values otherwise.
    assign det_id    = det_valid ? cur_id    : id_q;
    assign det_score = det_valid ? score     : score_q;
    assign det_hit   = det_valid ? score_pos : hit_q;

endmodule

// File: tb/tb_svm_win_sched.sv
// Bench for svm_win_sched: directed scenarios plus random traffic, checked every cycle
// against a window-level timing/score model.
module tb_svm_win_sched;

    localparam int N    = 4;
    localparam int SW   = 11;
    localparam int AW   = 2;
    localparam int DW   = 16;
    localparam int ACCW = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic            win_valid;
    logic [SW-1:0]   win_id;
    logic            win_ready;
    logic            rd_en;
    logic [AW-1:0]   term_addr;
    logic [DW-1:0]   feat_data;
    logic [DW-1:0]   w_data;
    logic [ACCW-1:0] bias;
    logic            det_valid;
    logic [SW-1:0]   det_id;
    logic [ACCW-1:0] det_score;
    logic            det_hit;

    svm_win_sched #(
        .SW_W(SW), .N_TERM(N), .ADDR_W(AW), .DATA_W(DW), .ACC_W(ACCW)
    ) dut (
        .clk(clk), .rst(rst),
        .win_valid(win_valid), .win_id(win_id), .win_ready(win_ready),
        .rd_en(rd_en), .term_addr(term_addr),
        .feat_data(feat_data), .w_data(w_data), .bias(bias),
        .det_valid(det_valid), .det_id(det_id), .det_score(det_score), .det_hit(det_hit)
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] feat_mem [N];
    logic signed [DW-1:0] w_mem [N];

    // Feature buffer and weight ROM: one-cycle read latency.
    always @(posedge clk) begin
        feat_data <= feat_mem[term_addr];
        w_data    <= w_mem[term_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // One entry per accepted window: accept cycle, load cycle, record cycle, id, score.
    int              q_acc[$];
    int              q_load[$];
    int              q_due[$];
    logic [SW-1:0]   q_id[$];
    logic [ACCW-1:0] q_score[$];

    logic [SW-1:0]   hold_id;
    logic [ACCW-1:0] hold_score;
    logic            hold_hit;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [ACCW-1:0] ref_score();
        longint s;
        s = longint'($signed(bias));
        for (int i = 0; i < N; i++)
            s += longint'(feat_mem[i]) * longint'(w_mem[i]);
        return ACCW'(s);
    endfunction

    task automatic model_clear();
        q_acc.delete(); q_load.delete(); q_due.delete(); q_id.delete(); q_score.delete();
        hold_id = '0; hold_score = '0; hold_hit = 1'b0;
    endtask

    task automatic check_cycle(output logic er);
        logic          erd, ev;
        logic [AW-1:0] ea;
        er = 1'b1; erd = 1'b0; ea = '0;
        foreach (q_due[i]) begin
            if (q_acc[i] < cyc && cyc <= q_load[i]) er = 1'b0;
            if (cyc > q_load[i] && cyc <= q_load[i] + N) begin
                erd = 1'b1;
                ea  = AW'(cyc - q_load[i] - 1);
            end
        end
        ev = (q_due.size() > 0) && (q_due[0] == cyc);
        chk("win_ready", 64'(win_ready), 64'(er));
        chk("rd_en", 64'(rd_en), 64'(erd));
        if (erd) chk("term_addr", 64'(term_addr), 64'(ea));
        chk("det_valid", 64'(det_valid), 64'(ev));
        if (ev) begin
            hold_id    = q_id[0];
            hold_score = q_score[0];
            hold_hit   = $signed(q_score[0]) > 0;
            void'(q_acc.pop_front()); void'(q_load.pop_front()); void'(q_due.pop_front());
            void'(q_id.pop_front());  void'(q_score.pop_front());
        end
        chk("det_id", 64'(det_id), 64'(hold_id));
        chk("det_score", 64'(det_score), 64'(hold_score));
        chk("det_hit", 64'(det_hit), 64'(hold_hit));
    endtask

    task automatic step(input logic v, input logic [SW-1:0] id, output logic accepted);
        logic er;
        int   ld;
        win_valid = v;
        win_id    = id;
        check_cycle(er);
        accepted = v && er;
        if (accepted) begin
            // Loaded the cycle after accept, but not before the previous window's OUT cycle.
            ld = cyc + 1;
            if (q_due.size() > 0 && q_due[$] > ld) ld = q_due[$];
            q_acc.push_back(cyc);
            q_load.push_back(ld);
            q_due.push_back(ld + N + 3);
            q_id.push_back(id);
            q_score.push_back(ref_score());
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) step(1'b0, '0, a);
    endtask

    task automatic drain();
        logic a;
        for (int k = 0; k < 100 && q_due.size() > 0; k++) step(1'b0, '0, a);
        chk("drain_timeout", 64'(q_due.size()), 64'd0);
        idle(2);
    endtask

    task automatic offer_until(input logic [SW-1:0] id, input string tag);
        logic a;
        a = 1'b0;
        for (int k = 0; k < 60 && !a; k++) step(1'b1, id, a);
        chk(tag, 64'(a), 64'd1);
    endtask

    task automatic set_mem(input logic signed [DW-1:0] f, input logic signed [DW-1:0] w,
                           input logic [ACCW-1:0] b);
        for (int i = 0; i < N; i++) begin
            feat_mem[i] = f;
            w_mem[i]    = w;
        end
        bias = b;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_det_valid"}, 64'(det_valid), 64'd0);
        chk({tag, "_det_id"}, 64'(det_id), 64'd0);
        chk({tag, "_det_score"}, 64'(det_score), 64'd0);
        chk({tag, "_det_hit"}, 64'(det_hit), 64'd0);
        chk({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        chk({tag, "_term_addr"}, 64'(term_addr), 64'd0);
        chk({tag, "_win_ready"}, 64'(win_ready), 64'd1);
    endtask

    initial begin
        logic a;
        int   ids[3];
        int   idx;

        win_valid = 1'b0;
        win_id    = '0;
        set_mem(16'sd1, 16'sd2, -20'sd5);
        model_clear();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;

        // Single window: score 4*2 - 5 = 3, record in cycle 8.
        step(1'b1, 11'd100, a);
        drain();

        set_mem(-16'sd3, 16'sd4, 20'd0);
        step(1'b1, 11'd101, a);
        drain();

        set_mem(16'sd1, 16'sd2, -20'sd8);
        step(1'b1, 11'd102, a);
        drain();

        // Back-to-back with win_valid held high.
        set_mem(16'sd5, -16'sd7, 20'sd100);
        ids = '{7, 8, 9};
        idx = 0;
        for (int k = 0; k < 80 && idx < 3; k++) begin
            step(1'b1, SW'(ids[idx]), a);
            if (a) idx++;
        end
        chk("b2b_all_accepted", 64'(idx), 64'd3);
        drain();

        // Pending slot: 20 accepted during 19's run, 21 held off until 20 loads.
        set_mem(16'sd2, 16'sd3, -20'sd30);
        step(1'b1, 11'd19, a);
        idle(2);
        offer_until(11'd20, "pend_accept_20");
        offer_until(11'd21, "pend_accept_21");
        drain();

        // Reset in the middle of RUN with a window pending.
        set_mem(16'sd9, 16'sd9, 20'sd1);
        step(1'b1, 11'd30, a);
        idle(1);
        step(1'b1, 11'd31, a);
        for (int k = 0; k < 10 && !(rd_en && term_addr == 2'd2); k++) idle(1);
        chk("mid_run_reached", 64'(rd_en && term_addr == 2'd2), 64'd1);
        rst = 1'b1;
        #1 check_reset_outputs("mid_reset");
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        idle(12);
        step(1'b1, 11'd40, a);
        drain();

        // Accumulator wrap in the 20-bit score.
        set_mem(16'sh7FFF, 16'sh7FFF, 20'd0);
        step(1'b1, 11'd50, a);
        drain();

        // Random traffic with random memory contents and bias.
        for (int i = 0; i < N; i++) begin
            feat_mem[i] = DW'($urandom);
            w_mem[i]    = DW'($urandom);
        end
        bias = ACCW'($urandom);
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 2) == 0, SW'($urandom), a);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/svm_win_sched.md
Name: svm_win_sched

Overview:
- Scoring sequencer for the linear SVM. Sits downstream of the slide-window controller.
- Takes each qualified slide-window index and time-multiplexes a single shared multiply-accumulate over the window's N_TERM feature/weight pairs. It generates read addresses into the feature buffer and the weight ROM.
- Adds the bias and emits one detection record per window.
- Holds one pending window, so the controller may issue the next index while the current one is being scored.

Parameters:
- SW_W, 11: slide-window index width.
- N_TERM, 3780: feature/weight pairs per window (must be ≥2).
- ADDR_W, 12: term address width (2^ADDR_W ≥ N_TERM).
- DATA_W, 16: signed feature and weight width.
- ACC_W, 40: signed accumulator, bias and score width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- win_valid  in  1  window index offered
- win_id  in  SW_W  slide-window index
- win_ready  out  1  pending slot free
- rd_en  out  1  read strobe to feature buffer and weight ROM
- term_addr  out  ADDR_W  term index for both memories
- feat_data  in  DATA_W  signed feature, valid 1 cycle after rd_en
- w_data  in  DATA_W  signed weight, valid 1 cycle after rd_en
- bias  in  ACC_W  signed bias, quasi-static
- det_valid  out  1  one-cycle detection record strobe
- det_id  out  SW_W  window index of record
- det_score  out  ACC_W  signed score
- det_hit  out  1  score > 0

Behaviour:
- Reset: all of the following are cleared.
  - state=IDLE, pend_v=0, acc=0, term_addr=0, rd_en=0.
  - det_valid=0, det_id=0, det_score=0, det_hit=0.
  - Reset is legal mid-run; the in-flight window and the pending window are discarded and no record is produced.
- Pending slot:
  - win_ready = !pend_v.
  - Accept = win_valid & win_ready; it latches win_id into pend_id and sets pend_v.
  - pend_v clears on the edge the window is loaded into the core. An accept in that same cycle is impossible, since win_ready was 0.
- FSM states: IDLE, RUN, DRAIN1, DRAIN2, OUT.
  - IDLE: if pend_v, go to RUN; load cur_id=pend_id, acc=0, term_addr=0.
  - RUN: rd_en=1; term_addr increments each cycle. On the cycle term_addr==N_TERM-1, go to DRAIN1 and term_addr returns to 0.
  - DRAIN1 → DRAIN2: unconditional. This covers memory latency and the product register.
  - OUT: det_valid=1. If pend_v, go directly to RUN with the same load actions as IDLE; otherwise go to IDLE.
- Datapath pipeline:
  - Stage 1: memory read (1 cycle).
  - Stage 2: registered signed product, width 2*DATA_W, with a valid bit.
  - Stage 3: acc += sign-extended product.
  - acc wraps two's complement; there is no saturation.
- Output record:
  - During OUT: det_id=cur_id, det_score=acc+bias (ACC_W, wrapping), det_hit=(det_score signed > 0).
  - det_score = 0 gives hit = 0.
  - Outside OUT: det_valid=0 and the other det_* outputs hold their last values.
- Latency: accept sampled at end of cycle 0 → RUN in cycles 2..N_TERM+1 → det_valid in cycle N_TERM+4.
- Throughput: back-to-back windows give one record every N_TERM+3 cycles.
- rd_en is never asserted outside RUN.
- win_valid must not depend on win_ready.

Test Plan:
- Single window, N_TERM=4. All feats=1, weights=2, bias=-5, win_id=100 accepted in cycle 0 → rd_en in cycles 2-5 with term_addr 0,1,2,3; det_valid only in cycle 8 with det_id=100, det_score=3, det_hit=1.
- Sign and zero boundary, N_TERM=4.
  - feats=-3, weights=4, bias=0 → det_score=-48, det_hit=0.
  - feats=1, weights=2, bias=-8 → det_score=0, det_hit=0.
- Back-to-back: win_valid held high with ids 7,8,9 from cycle 0.
  - win_ready deasserts while pending is full.
  - det_valid in cycles 8, 15, 22 with ids 7, 8, 9.
  - No window lost or duplicated.
- Pending held: offer id 20 during the RUN of id 19 → accepted immediately; id 21 offered next is held off (win_ready=0) until id 20 loads at OUT.
- Reset mid-RUN (assert rst at term_addr=2 with one window pending) → all outputs 0 asynchronously; after release, no det_valid without a new accept; a new window scores correctly.
- Accumulator wrap, ACC_W=20: feats=weights=0x7FFF, N_TERM=4 → det_score equals the 20-bit wrapped sum; no X's on outputs.
